// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and imem requester feeding a DEPTH-entry prefetch queue to decode.
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic [INST_W-1:0]          imem_inst_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [ADDR_W-1:0]          npc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] r_pc, r_pc_hold, r_npc_hold;
  logic [ADDR_W-1:0] r_mem_pc [DEPTH];
  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_running;
  logic              w_push, w_pop;
  assign valid_o     = r_count != '0;
  assign imem_req_o  = r_running & (r_count < CW'(DEPTH)) & ~redirect_i;
  assign imem_addr_o = r_pc;
  assign count_o     = r_count;
  assign w_push      = imem_req_o & imem_gnt_i;
  assign w_pop       = valid_o & ready_i;
  // pc_o/npc_o keep the last shown head while the queue is empty
  assign inst_o = valid_o ? r_mem_inst[r_rptr] : '0;
  assign pc_o   = valid_o ? r_mem_pc[r_rptr] : r_pc_hold;
  assign npc_o  = valid_o ? r_mem_pc[r_rptr] + ADDR_W'(PC_STEP) : r_npc_hold;
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_pc;
      r_mem_inst[r_wptr] <= imem_inst_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_running  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_pc_hold  <= '0;
      r_npc_hold <= '0;
    end else begin
      r_running <= r_running | start_i;
      if (valid_o) begin
        r_pc_hold  <= pc_o;
        r_npc_hold <= npc_o;
      end
      if (redirect_i) begin
        r_pc    <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
          r_pc   <= r_pc + ADDR_W'(PC_STEP);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule
